inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_npc_sel.sv | 19 +
 rtl/inst_fetch.sv | 85 ++++++++
 tb/tb_inst_fetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU width, boot address, NOP and fetch state type (TRAP only with FETCH_MISALIGN_TRAP_EN)
package cpu_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] BOOT_ADDR_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {BOOT, RUN, HOLD, TRAP} fetch_state_t;
`else
   typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;
`endif
endpackage

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel: picks the address issued to the ROM this cycle and the sequential address after it
module fetch_npc_sel
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_ADDR = BOOT_ADDR_DEF
) (
   input  fetch_state_t    state,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] fetch_addr,
   output logic [XLEN-1:0] next_pc
);
   // boot address first, then a qualified redirect, otherwise the running fetch pointer; +4 wraps mod 2^32
   always_comb begin
      fetch_addr = state == BOOT ? BOOT_ADDR : redirect ? redirect_pc : fetch_pc;
      next_pc = fetch_addr + XLEN'(4);
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage with boot, stall hold and redirect; define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_ADDR = BOOT_ADDR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] imem_data,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_en,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc4_o,
   output logic            valid_o,
   output logic            misalign_o
);
   fetch_state_t state, state_nx, redir_st;
   logic [XLEN-1:0] fetch_pc, fetch_addr, next_pc, hold_reg, rpc;
   logic live, take_redir, advance;

   assign live = state == RUN || state == HOLD;
   assign take_redir = live && redirect;
   assign advance = state == BOOT || take_redir || (live && !stall);
   assign pc4_o = pc_o + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic mis_redir, misalign_q;
   assign rpc = redirect_pc;
   assign mis_redir = take_redir && redirect_pc[1:0] != 2'b00;
   assign redir_st = mis_redir ? TRAP : RUN;
   assign misalign_o = misalign_q;
   // misalignment flag stays set until reset
   always_ff @(posedge clk or negedge rst)
      if (!rst) misalign_q <= 1'b0;
      else if (mis_redir) misalign_q <= 1'b1;
`else
   assign rpc = redirect_pc & ~XLEN'(3);
   assign redir_st = RUN;
   assign misalign_o = 1'b0;
`endif

   fetch_npc_sel #(.BOOT_ADDR(BOOT_ADDR)) u_npc (
      .state(state),
      .redirect(take_redir),
      .redirect_pc(rpc),
      .fetch_pc(fetch_pc),
      .fetch_addr(fetch_addr),
      .next_pc(next_pc)
   );

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= BOOT;
      else state <= state_nx;

   // next state: boot always runs, redirect beats stall, anything else holds its state
   always_comb state_nx = state == BOOT ? RUN : take_redir ? redir_st : live ? (stall ? HOLD : RUN) : state;

   // pc_o tracks the address whose data arrives next cycle; the held word is dropped on redirect
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fetch_pc <= BOOT_ADDR;
         pc_o <= BOOT_ADDR;
         hold_reg <= '0;
      end else begin
         if (advance) begin
            pc_o <= fetch_addr;
            fetch_pc <= next_pc;
         end
         if (take_redir) hold_reg <= '0;
         else if (state == RUN && stall) hold_reg <= imem_data;
      end

   // ROM access and the instruction presented downstream
   always_comb begin
      imem_addr = fetch_addr;
      imem_en = advance;
      valid_o = live;
      inst_o = state == RUN ? imem_data : state == HOLD ? hold_reg : '0;
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a stream-level reference model checked every cycle
module tb_inst_fetch;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_data = 32'h0, imem_addr, inst_o, pc_o, pc4_o;
   logic imem_en, valid_o, misalign_o;
   logic [31:0] imem_data2 = 32'h0, imem_addr2, inst_o2, pc_o2, pc4_o2;
   logic imem_en2, valid_o2, misalign_o2;
   int total = 0, bad = 0;

   inst_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_data(imem_data), .imem_addr(imem_addr), .imem_en(imem_en), .inst_o(inst_o),
      .pc_o(pc_o), .pc4_o(pc4_o), .valid_o(valid_o), .misalign_o(misalign_o)
   );

   inst_fetch #(.BOOT_ADDR(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_data(imem_data2), .imem_addr(imem_addr2), .imem_en(imem_en2), .inst_o(inst_o2),
      .pc_o(pc_o2), .pc4_o(pc4_o2), .valid_o(valid_o2), .misalign_o(misalign_o2)
   );

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   always @(posedge clk) if (imem_en) imem_data <= rom_f(imem_addr);
   always @(posedge clk) if (imem_en2) imem_data2 <= rom_f(imem_addr2);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // stream model: after boot one instruction per unstalled cycle, redirect jumps, misaligned redirect traps
   logic m_valid, m_trap;
   logic [31:0] m_pc;
   always @(posedge clk or negedge rst)
      if (!rst) begin
         m_valid <= 1'b0;
         m_trap <= 1'b0;
         m_pc <= 32'h0;
      end else if (!m_valid) m_valid <= 1'b1;
      else if (!m_trap) begin
         if (redirect) begin
            if (TRAP_EN && redirect_pc[1:0] != 2'b00) m_trap <= 1'b1;
            else m_pc <= redirect_pc & 32'hFFFF_FFFC;
         end else if (!stall) m_pc <= m_pc + 32'd4;
      end

   logic e_live, e_en;
   logic [31:0] e_addr, e_inst;
   assign e_live = m_valid && !m_trap;
   assign e_en = !m_trap && (!m_valid || redirect || !stall);
   assign e_addr = !m_valid ? 32'h0 : redirect ? (TRAP_EN ? redirect_pc : redirect_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
   assign e_inst = e_live ? rom_f(m_pc) : 32'h0;

   always @(negedge clk) begin
      chk("valid", valid_o, e_live);
      chk("inst", inst_o, e_inst);
      chk("en", imem_en, e_en);
      chk("misalign", misalign_o, m_trap);
      if (!m_trap) begin
         chk("pc", pc_o, m_pc);
         chk("pc4", pc4_o, m_pc + 32'd4);
      end
      if (e_en) chk("addr", imem_addr, e_addr);
   end

   task automatic step(input logic s, input logic r, input logic [31:0] rp);
      @(posedge clk);
      #1;
      stall = s;
      redirect = r;
      redirect_pc = rp;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h80;
      @(negedge clk);
      chk("boot_valid", valid_o, 0);
      chk("boot_addr", imem_addr, 32'h0);
      chk("boot_en", imem_en, 1);
      chk("boot_inst", inst_o, 32'h0);
      chk("boot2_addr", imem_addr2, 32'hFFFF_FFF8);
      chk("boot2_valid", valid_o2, 0);
      step(0, 0, 0);
      chk("run_pc0", pc_o, 32'h0);
      chk("run_inst0", inst_o, 32'h0);
      chk("run_valid0", valid_o, 1);
      chk("wrap_pc0", pc_o2, 32'hFFFF_FFF8);
      chk("wrap_inst0", inst_o2, 32'h3FFF_FFFE);
      step(0, 0, 0);
      chk("run_pc1", pc_o, 32'h4);
      chk("run_inst1", inst_o, 32'h1);
      chk("wrap_pc1", pc_o2, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4_o2, 32'h0);
      step(1, 0, 0);
      chk("stall_pc_a", pc_o, 32'h8);
      chk("stall_inst_a", inst_o, 32'h2);
      chk("stall_en_a", imem_en, 0);
      chk("wrap_pc2", pc_o2, 32'h0);
      chk("wrap_inst2", inst_o2, 32'h0);
      step(1, 0, 0);
      chk("stall_pc_b", pc_o, 32'h8);
      chk("stall_en_b", imem_en, 0);
      step(1, 0, 0);
      chk("stall_pc_c", pc_o, 32'h8);
      chk("stall_inst_c", inst_o, 32'h2);
      step(0, 0, 0);
      chk("release_pc", pc_o, 32'h8);
      chk("release_en", imem_en, 1);
      chk("release_addr", imem_addr, 32'hC);
      step(0, 0, 0);
      chk("after_stall_pc", pc_o, 32'hC);
      chk("after_stall_inst", inst_o, 32'h3);
      step(1, 1, 32'h40);
      chk("redir_stall_addr", imem_addr, 32'h40);
      chk("redir_stall_en", imem_en, 1);
      step(0, 0, 0);
      chk("redir_pc", pc_o, 32'h40);
      chk("redir_valid", valid_o, 1);
      chk("redir_inst", inst_o, 32'h10);
      step(1, 0, 0);
      step(1, 1, 32'h80);
      chk("hold_redir_inst", inst_o, 32'h11);
      chk("hold_redir_addr", imem_addr, 32'h80);
      step(0, 0, 0);
      chk("hold_redir_pc", pc_o, 32'h80);
      chk("hold_redir_new", inst_o, 32'h20);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("hold_inst", inst_o, 32'h21);
      #2;
      rst = 1'b0;
      #1;
      chk("async_valid", valid_o, 0);
      chk("async_pc", pc_o, 32'h0);
      chk("async_inst", inst_o, 32'h0);
      #1;
      rst = 1'b1;
      step(0, 0, 0);
      chk("post_rst_pc", pc_o, 32'h0);
      chk("post_rst_valid", valid_o, 1);
      step(0, 0, 0);
      chk("post_rst_pc1", pc_o, 32'h4);
      step(0, 1, 32'h42);
      chk("mis_en", imem_en, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_addr", imem_addr, 32'h42);
      step(0, 0, 0);
      chk("trap_valid", valid_o, 0);
      chk("trap_flag", misalign_o, 1);
      chk("trap_en", imem_en, 0);
      step(1, 1, 32'h100);
      step(0, 0, 0);
      chk("trap_valid_late", valid_o, 0);
      chk("trap_flag_late", misalign_o, 1);
`else
      chk("mis_addr", imem_addr, 32'h40);
      step(0, 0, 0);
      chk("mis_pc", pc_o, 32'h40);
      chk("mis_flag", misalign_o, 0);
      step(1, 1, 32'h100);
      step(0, 0, 0);
      chk("late_pc", pc_o, 32'h100);
      chk("late_inst", inst_o, 32'h40);
`endif
      step(0, 0, 0);
      step(0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
